chain_stimulus_sequencer: RTL and testbench

Programmable pulse-train generator and edge monitor for the NOR/inverter delay-chain test structures. It drives the chain input with N pulses of configurable high width and low gap, measured in clock cycles. It counts the transitions that arrive at the chain output, which exposes pulse cancellation and degradation along the chain. It sits between the test-control registers and the chain's input/output pins, and handles one run at a time through a start/busy/done handshake.

---
 rtl/chain_stimulus_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_chain_stimulus_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/chain_stimulus_sequencer.sv
// Pulse-train driver and synchronized edge counter for delay-chain test structures.
// Optional macro CHAIN_STIM_LATENCY_EN adds the first_edge_lat output and its counter.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for start; outputs hold last-run results
// S_HIGH   | chain_in driven high for the shadowed high width
// S_LOW    | chain_in low for max(low,1) cycles; pulse counted
// S_SETTLE | chain_in low while the tail edges drain in
// S_DONE   | one-cycle done pulse, lost_pulse updated
module chain_stimulus_sequencer #(
  parameter int CNT_W      = 8,
  parameter int NUM_W      = 8,
  parameter int EDGE_W     = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  high_cycles,
  input  logic [CNT_W-1:0]  low_cycles,
  input  logic [NUM_W-1:0]  num_pulses,
  output logic              busy,
  output logic              done,
  output logic              chain_in,
  input  logic              chain_out,
  output logic [EDGE_W-1:0] edge_count,
  output logic              lost_pulse
`ifdef CHAIN_STIM_LATENCY_EN
  ,
  output logic [EDGE_W-1:0] first_edge_lat
`endif
);

  localparam int ST_W  = $clog2(SETTLE_CYC + 1);
  localparam int PH_W  = (CNT_W > ST_W) ? CNT_W : ST_W;
  localparam int CMP_W = (EDGE_W > NUM_W + 1) ? EDGE_W : NUM_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [PH_W-1:0]   ph_cnt, ph_nx;
  logic [NUM_W-1:0]  pul_cnt, pul_nx;
  logic [CNT_W-1:0]  sh_high, sh_low;
  logic [NUM_W-1:0]  sh_num;
  logic              sync1, sync2, sync3;
  logic [EDGE_W-1:0] edge_nx;
  logic              accept, zero_run, count_en;
  logic [CNT_W-1:0]  low_eff;

  assign accept   = (state == S_IDLE) && start;
  assign zero_run = (num_pulses == '0) || (high_cycles == '0);
  assign low_eff  = (low_cycles == '0) ? CNT_W'(1) : low_cycles;
  assign count_en = busy && (sync2 ^ sync3);

  always_comb begin
    state_nx = state;
    ph_nx    = ph_cnt;
    pul_nx   = pul_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          pul_nx = num_pulses;
          if (zero_run) begin
            state_nx = S_SETTLE;
            ph_nx    = PH_W'(SETTLE_CYC - 1);
          end else begin
            state_nx = S_HIGH;
            ph_nx    = PH_W'(high_cycles - CNT_W'(1));
          end
        end
      end
      S_HIGH: begin
        if (ph_cnt == '0) begin
          state_nx = S_LOW;
          ph_nx    = PH_W'(sh_low - CNT_W'(1));
        end else begin
          ph_nx = ph_cnt - PH_W'(1);
        end
      end
      S_LOW: begin
        if (ph_cnt == '0) begin
          pul_nx = pul_cnt - NUM_W'(1);
          if (pul_cnt == NUM_W'(1)) begin
            state_nx = S_SETTLE;
            ph_nx    = PH_W'(SETTLE_CYC - 1);
          end else begin
            state_nx = S_HIGH;
            ph_nx    = PH_W'(sh_high - CNT_W'(1));
          end
        end else begin
          ph_nx = ph_cnt - PH_W'(1);
        end
      end
      S_SETTLE: begin
        if (ph_cnt == '0) state_nx = S_DONE;
        else              ph_nx = ph_cnt - PH_W'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ph_cnt   <= '0;
      pul_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      chain_in <= 1'b0;
    end else begin
      state    <= state_nx;
      ph_cnt   <= ph_nx;
      pul_cnt  <= pul_nx;
      busy     <= (state_nx != S_IDLE);
      done     <= (state_nx == S_DONE);
      chain_in <= (state_nx == S_HIGH);
    end
  end

  // A zero-width run issues no pulses, so its expected edge count is zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_high <= '0;
      sh_low  <= '0;
      sh_num  <= '0;
    end else if (accept) begin
      sh_high <= high_cycles;
      sh_low  <= low_eff;
      sh_num  <= (high_cycles == '0) ? '0 : num_pulses;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= chain_out;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_comb begin
    edge_nx = edge_count;
    if (count_en && !(&edge_count)) edge_nx = edge_count + EDGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
      lost_pulse <= 1'b0;
    end else if (accept) begin
      edge_count <= '0;
      lost_pulse <= 1'b0;
    end else begin
      edge_count <= edge_nx;
      if (state == S_DONE)
        lost_pulse <= (CMP_W'(edge_nx) != CMP_W'({sh_num, 1'b0}));
    end
  end

`ifdef CHAIN_STIM_LATENCY_EN
  logic [EDGE_W-1:0] lat_cnt;
  logic              lat_run, lat_got;

  // The first rise always lands in the cycle after acceptance, so the counter arms at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt        <= '0;
      lat_run        <= 1'b0;
      lat_got        <= 1'b0;
      first_edge_lat <= '0;
    end else if (accept) begin
      lat_cnt        <= '0;
      lat_run        <= !zero_run;
      lat_got        <= 1'b0;
      first_edge_lat <= '0;
    end else begin
      if (lat_run && !(&lat_cnt)) lat_cnt <= lat_cnt + EDGE_W'(1);
      if (count_en && lat_run && !lat_got) begin
        first_edge_lat <= lat_cnt;
        lat_got        <= 1'b1;
      end
      if (state == S_DONE) lat_run <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_chain_stimulus_sequencer.sv
// Directed bench for chain_stimulus_sequencer: table of runs through a loopback
// or pulse-filter chain model, plus reset, idle-edge and saturation sequences.
module tb_chain_stimulus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] high_cycles = '0, low_cycles = '0, num_pulses = '0;
  logic       busy, done, chain_in, chain_out, lost_pulse;
  logic [15:0] edge_count;

  logic       filt = 1'b0, use_force = 1'b0, force_out = 1'b0;
  logic       q1 = 1'b0, q2 = 1'b0;

  logic       s_start = 1'b0;
  logic [7:0] s_high = '0, s_low = '0, s_num = '0;
  logic       s_busy, s_done, s_chain_in, s_lost;
  logic       s_q1 = 1'b0;
  logic [3:0] s_edges;

`ifdef CHAIN_STIM_LATENCY_EN
  logic [15:0] first_edge_lat;
  logic [3:0]  s_fel;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q1   <= chain_in;
    q2   <= q1;
    s_q1 <= s_chain_in;
  end
  assign chain_out = use_force ? force_out : (filt ? (q1 & q2) : q1);

  chain_stimulus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .high_cycles(high_cycles), .low_cycles(low_cycles), .num_pulses(num_pulses),
    .busy(busy), .done(done), .chain_in(chain_in), .chain_out(chain_out),
    .edge_count(edge_count), .lost_pulse(lost_pulse)
`ifdef CHAIN_STIM_LATENCY_EN
    , .first_edge_lat(first_edge_lat)
`endif
  );

  chain_stimulus_sequencer #(.EDGE_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .high_cycles(s_high), .low_cycles(s_low), .num_pulses(s_num),
    .busy(s_busy), .done(s_done), .chain_in(s_chain_in), .chain_out(s_q1),
    .edge_count(s_edges), .lost_pulse(s_lost)
`ifdef CHAIN_STIM_LATENCY_EN
    , .first_edge_lat(s_fel)
`endif
  );

  typedef struct {
    logic [7:0] high, low, num;
    bit         filt, poke;
    int         lat, edges;
    bit         lost;
    int         rises, highs;
    logic [5:0] seq;
    int         fel;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, busy_n, rises, highs;
    logic [5:0] seq;
    logic prev;
    bit timeout;
    high_cycles = v.high; low_cycles = v.low; num_pulses = v.num; filt = v.filt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; busy_n = 0; rises = 0; highs = 0; seq = '0; prev = 1'b0; timeout = 0;
    forever begin
      if (busy) busy_n++;
      if (cyc < 6) seq = {seq[4:0], chain_in};
      if (chain_in) highs++;
      if (chain_in && !prev) rises++;
      prev = chain_in;
      if (done) break;
      if (cyc >= 2000) begin timeout = 1; break; end
      if (v.poke && cyc == 3) begin
        start = 1'b1; high_cycles = 8'd7; low_cycles = 8'd4; num_pulses = 8'd9;
      end
      if (v.poke && cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_timeout", idx), 32'(timeout), 32'd0);
    chk($sformatf("v%0d_done_lat", idx), 32'(cyc), 32'(v.lat));
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'(v.lat + 1));
    chk($sformatf("v%0d_rises", idx), 32'(rises), 32'(v.rises));
    chk($sformatf("v%0d_high_cycles", idx), 32'(highs), 32'(v.highs));
    chk($sformatf("v%0d_seq", idx), 32'(seq), 32'(v.seq));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d_busy_after", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_edges", idx), 32'(edge_count), 32'(v.edges));
    chk($sformatf("v%0d_lost", idx), 32'(lost_pulse), 32'(v.lost));
`ifdef CHAIN_STIM_LATENCY_EN
    chk($sformatf("v%0d_first_lat", idx), 32'(first_edge_lat), 32'(v.fel));
`endif
  endtask

  task automatic run_sat(input logic [7:0] n, input int exp_edges, input bit exp_lost);
    int cyc;
    s_high = 8'd1; s_low = 8'd1; s_num = n;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("sat%0d_done_lat", n), 32'(cyc), 32'(2 * n + 8));
    @(negedge clk);
    chk($sformatf("sat%0d_edges", n), 32'(s_edges), 32'(exp_edges));
    chk($sformatf("sat%0d_lost", n), 32'(s_lost), 32'(exp_lost));
`ifdef CHAIN_STIM_LATENCY_EN
    chk($sformatf("sat%0d_first_lat", n), 32'(s_fel), 32'd3);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          high   low    num    filt  poke  lat edges lost rises highs seq        fel
    vecs[0] = '{8'd3, 8'd2, 8'd4, 1'b0, 1'b0, 28, 8,  1'b0, 4, 12, 6'b111001, 3};
    vecs[1] = '{8'd1, 8'd1, 8'd5, 1'b1, 1'b0, 18, 0,  1'b1, 5, 5,  6'b101010, 0};
    vecs[2] = '{8'd0, 8'd2, 8'd3, 1'b0, 1'b0, 8,  0,  1'b0, 0, 0,  6'b000000, 0};
    vecs[3] = '{8'd2, 8'd0, 8'd2, 1'b0, 1'b0, 14, 4,  1'b0, 2, 4,  6'b110110, 3};
    vecs[4] = '{8'd5, 8'd3, 8'd0, 1'b0, 1'b0, 8,  0,  1'b0, 0, 0,  6'b000000, 0};
    vecs[5] = '{8'd1, 8'd1, 8'd5, 1'b0, 1'b0, 18, 10, 1'b0, 5, 5,  6'b101010, 3};
    vecs[6] = '{8'd2, 8'd1, 8'd3, 1'b1, 1'b0, 17, 6,  1'b0, 3, 6,  6'b110110, 4};
    vecs[7] = '{8'd2, 8'd1, 8'd3, 1'b0, 1'b1, 17, 6,  1'b0, 3, 6,  6'b110110, 3};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_chain_in", 32'(chain_in), 32'd0);
    chk("rst_edges", 32'(edge_count), 32'd0);
    chk("rst_lost", 32'(lost_pulse), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // chain_out activity while idle must leave the last result untouched
    use_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      force_out = ~force_out;
      @(negedge clk);
    end
    force_out = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_edges", 32'(edge_count), 32'(vecs[7].edges));
    use_force = 1'b0;
    repeat (2) @(negedge clk);

    // reset during the second HIGH phase
    high_cycles = 8'd3; low_cycles = 8'd2; num_pulses = 8'd4; filt = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_chain_in", 32'(chain_in), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_edges", 32'(edge_count), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_chain_in", 32'(chain_in), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_edges", 32'(edge_count), 32'd0);
    chk("mid_rst_lost", 32'(lost_pulse), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_vec(vecs[0], 8);

    run_sat(8'd10, 15, 1'b1);
    run_sat(8'd7, 14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
